dic_set_sequencer: RTL and testbench

//  Command sequencer for the digital clock. Consumes decoded UART character strobes and

---
 rtl/dic_pkg.sv | 54 +++++
 rtl/dic_set_sequencer_if.sv | 42 ++++
 rtl/dic_timeout_ctr.sv | 34 +++
 rtl/dic_set_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dic_set_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dic_pkg.sv
// Shared types and constants for the digital-clock set sequencer: FSM states,
// entry mode, digit width and entry-buffer slot indices.
package dic_pkg;

    localparam int DIGIT_W         = 4;
    localparam int TIMEOUT_SEC_DEF = 10;
    localparam int NUM_SLOTS       = 4;

    localparam logic [1:0] SLOT_MT = 2'd0;
    localparam logic [1:0] SLOT_MO = 2'd1;
    localparam logic [1:0] SLOT_ST = 2'd2;
    localparam logic [1:0] SLOT_SO = 2'd3;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_MT   = 3'd1,
        ST_D_MO   = 3'd2,
        ST_D_ST   = 3'd3,
        ST_D_SO   = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    typedef enum logic {
        MODE_TIME  = 1'b0,
        MODE_ALARM = 1'b1
    } mode_e;

    function automatic logic is_entry_state(input state_e s);
        return (s == ST_D_MT) || (s == ST_D_MO) || (s == ST_D_ST) || (s == ST_D_SO);
    endfunction

    function automatic logic [1:0] slot_of(input state_e s);
        case (s)
            ST_D_MT: return SLOT_MT;
            ST_D_MO: return SLOT_MO;
            ST_D_ST: return SLOT_ST;
            ST_D_SO: return SLOT_SO;
            default: return SLOT_MT;
        endcase
    endfunction

    function automatic state_e next_digit_state(input state_e s);
        case (s)
            ST_D_MT: return ST_D_MO;
            ST_D_MO: return ST_D_ST;
            ST_D_ST: return ST_D_SO;
            ST_D_SO: return ST_COMMIT;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dic_set_sequencer_if.sv
// Character-strobe inputs and control/digit outputs of the set sequencer.
// The sequencer is the slave; the UART decoder / clock datapath side is the master.
interface dic_set_sequencer_if import dic_pkg::*; ();

    logic   rx_valid;
    digit_t rx_digit;
    logic   det_num;
    logic   det_num0to5;
    logic   det_cr;
    logic   det_atSign;
    logic   det_A;
    logic   det_L;
    logic   det_S;
    logic   sec_tick;

    logic   clk_run;
    logic   alarm_ena;
    logic   ld_time;
    logic   ld_alarm;
    logic   commit_time;
    logic   commit_alarm;
    logic   entry_err;
    digit_t dig_mtens;
    digit_t dig_mones;
    digit_t dig_stens;
    digit_t dig_sones;

    modport master (
        output rx_valid, rx_digit, det_num, det_num0to5, det_cr, det_atSign,
               det_A, det_L, det_S, sec_tick,
        input  clk_run, alarm_ena, ld_time, ld_alarm, commit_time, commit_alarm,
               entry_err, dig_mtens, dig_mones, dig_stens, dig_sones
    );

    modport slave (
        input  rx_valid, rx_digit, det_num, det_num0to5, det_cr, det_atSign,
               det_A, det_L, det_S, sec_tick,
        output clk_run, alarm_ena, ld_time, ld_alarm, commit_time, commit_alarm,
               entry_err, dig_mtens, dig_mones, dig_stens, dig_sones
    );

endinterface

// File: rtl/dic_timeout_ctr.sv
// Entry inactivity counter: counts sec_tick pulses since the last clear and flags
// the tick that brings the count up to TIMEOUT_SEC.
module dic_timeout_ctr #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Tick counter; clear has priority so a digit arriving with a tick restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Expiry is signalled on the tick itself so the abort lands on that same edge.
    assign o_expired = i_tick & (r_cnt == LIMIT_M1);

endmodule

// File: rtl/dic_set_sequencer.sv
// Command sequencer for the digital clock: run/stop, alarm arm, and buffered MM:SS
// entry for time or alarm, committed atomically to the dig_* output registers.
module dic_set_sequencer import dic_pkg::*; #(
    parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dic_set_sequencer_if.slave bus
);

    state_e r_state, w_state_nxt;
    mode_e  r_mode,  w_mode_nxt;
    logic   r_run_ena, w_run_ena_nxt;
    logic   r_alarm_ena, w_alarm_ena_nxt;
    digit_t r_buf [NUM_SLOTS];
    digit_t w_buf_nxt [NUM_SLOTS];
    digit_t r_dig [NUM_SLOTS];
    digit_t w_dig_nxt [NUM_SLOTS];
    logic   r_commit_time, w_commit_time_nxt;
    logic   r_commit_alarm, w_commit_alarm_nxt;
    logic   r_entry_err, w_entry_err_nxt;
    logic   r_ld_time, r_ld_alarm, r_clk_run;

    logic   w_in_entry;
    logic   w_needs_0to5;
    logic   w_restart;
    logic   w_digit_ok;
    logic   w_ctr_clear;
    logic   w_ctr_tick;
    logic   w_expired;
    logic   w_ld_time_nxt;
    logic   w_ld_alarm_nxt;

    // Entry-state character classification, kept outside the FSM block so the
    // timeout counter controls never depend on its own expiry output.
    assign w_in_entry   = is_entry_state(r_state);
    assign w_needs_0to5 = (r_state == ST_D_MT) || (r_state == ST_D_ST);
    assign w_restart    = w_in_entry & bus.rx_valid & (bus.det_L | bus.det_A);
    assign w_digit_ok   = w_in_entry & bus.rx_valid & ~bus.det_L & ~bus.det_A & ~bus.det_S
                        & ~bus.det_cr & ~bus.det_atSign
                        & (w_needs_0to5 ? bus.det_num0to5 : bus.det_num);
    assign w_ctr_clear  = ~w_in_entry | w_digit_ok | w_restart;
    assign w_ctr_tick   = w_in_entry & bus.sec_tick;

    dic_timeout_ctr #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_ctr_clear),
        .i_tick    (w_ctr_tick),
        .o_expired (w_expired)
    );

    // Next-state, buffer and pulse logic for the command/entry FSM.
    always_comb begin
        w_state_nxt        = r_state;
        w_mode_nxt         = r_mode;
        w_run_ena_nxt      = r_run_ena;
        w_alarm_ena_nxt    = r_alarm_ena;
        w_buf_nxt          = r_buf;
        w_dig_nxt          = r_dig;
        w_commit_time_nxt  = 1'b0;
        w_commit_alarm_nxt = 1'b0;
        w_entry_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.det_L) begin
                        w_state_nxt = ST_D_MT;
                        w_mode_nxt  = MODE_TIME;
                        w_buf_nxt   = '{default: '0};
                    end else if (bus.det_A) begin
                        w_state_nxt = ST_D_MT;
                        w_mode_nxt  = MODE_ALARM;
                        w_buf_nxt   = '{default: '0};
                    end else if (bus.det_S) begin
                        w_run_ena_nxt = 1'b1;
                    end else if (bus.det_cr) begin
                        w_run_ena_nxt = 1'b0;
                    end else if (bus.det_atSign) begin
                        w_alarm_ena_nxt = ~r_alarm_ena;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_D_MT, ST_D_MO, ST_D_ST, ST_D_SO: begin
                if (w_restart) begin
                    w_state_nxt = ST_D_MT;
                    w_mode_nxt  = bus.det_L ? MODE_TIME : MODE_ALARM;
                    w_buf_nxt   = '{default: '0};
                end else if (w_digit_ok) begin
                    w_buf_nxt[slot_of(r_state)] = bus.rx_digit;
                    w_state_nxt = next_digit_state(r_state);
                    // Last digit: publish the completed buffer together with the pulse.
                    if (r_state == ST_D_SO) begin
                        w_dig_nxt          = w_buf_nxt;
                        w_commit_time_nxt  = (r_mode == MODE_TIME);
                        w_commit_alarm_nxt = (r_mode == MODE_ALARM);
                    end else begin
                        w_dig_nxt = r_dig;
                    end
                end else if (bus.rx_valid) begin
                    w_state_nxt     = ST_IDLE;
                    w_entry_err_nxt = bus.det_S | ~bus.det_cr;
                end else if (w_expired) begin
                    w_state_nxt     = ST_IDLE;
                    w_entry_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_ld_time_nxt  = is_entry_state(w_state_nxt) & (w_mode_nxt == MODE_TIME);
    assign w_ld_alarm_nxt = is_entry_state(w_state_nxt) & (w_mode_nxt == MODE_ALARM);

    // State, buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_mode         <= MODE_TIME;
            r_run_ena      <= 1'b0;
            r_alarm_ena    <= 1'b0;
            r_buf          <= '{default: '0};
            r_dig          <= '{default: '0};
            r_commit_time  <= 1'b0;
            r_commit_alarm <= 1'b0;
            r_entry_err    <= 1'b0;
            r_ld_time      <= 1'b0;
            r_ld_alarm     <= 1'b0;
            r_clk_run      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mode         <= w_mode_nxt;
            r_run_ena      <= w_run_ena_nxt;
            r_alarm_ena    <= w_alarm_ena_nxt;
            r_buf          <= w_buf_nxt;
            r_dig          <= w_dig_nxt;
            r_commit_time  <= w_commit_time_nxt;
            r_commit_alarm <= w_commit_alarm_nxt;
            r_entry_err    <= w_entry_err_nxt;
            r_ld_time      <= w_ld_time_nxt;
            r_ld_alarm     <= w_ld_alarm_nxt;
            r_clk_run      <= w_run_ena_nxt & ~w_ld_time_nxt;
        end
    end

    assign bus.clk_run      = r_clk_run;
    assign bus.alarm_ena    = r_alarm_ena;
    assign bus.ld_time      = r_ld_time;
    assign bus.ld_alarm     = r_ld_alarm;
    assign bus.commit_time  = r_commit_time;
    assign bus.commit_alarm = r_commit_alarm;
    assign bus.entry_err    = r_entry_err;
    assign bus.dig_mtens    = r_dig[SLOT_MT];
    assign bus.dig_mones    = r_dig[SLOT_MO];
    assign bus.dig_stens    = r_dig[SLOT_ST];
    assign bus.dig_sones    = r_dig[SLOT_SO];

endmodule

// File: tb/tb_dic_set_sequencer.sv
// Directed self-checking bench for dic_set_sequencer: entry, commit, abort,
// timeout, run/stop and restart scenarios with hand-computed expectations.
module tb_dic_set_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dic_set_sequencer_if bif ();

    dic_set_sequencer #(.TIMEOUT_SEC(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cnt_ct  = 0;
    int cnt_ca  = 0;
    int cnt_err = 0;

    logic [15:0] dig_all;
    logic [22:0] outs_all;
    assign dig_all  = {bif.dig_mtens, bif.dig_mones, bif.dig_stens, bif.dig_sones};
    assign outs_all = {bif.clk_run, bif.alarm_ena, bif.ld_time, bif.ld_alarm,
                       bif.commit_time, bif.commit_alarm, bif.entry_err, dig_all};

    // Pulse-cycle counters, sampled at the edge that ends each cycle.
    always @(posedge clk) begin
        if (bif.commit_time)  cnt_ct  <= cnt_ct + 1;
        if (bif.commit_alarm) cnt_ca  <= cnt_ca + 1;
        if (bif.entry_err)    cnt_err <= cnt_err + 1;
    end

    task automatic clear_inputs();
        bif.rx_valid = 1'b0; bif.rx_digit = 4'd0; bif.det_num = 1'b0; bif.det_num0to5 = 1'b0;
        bif.det_cr = 1'b0; bif.det_atSign = 1'b0; bif.det_A = 1'b0; bif.det_L = 1'b0;
        bif.det_S = 1'b0; bif.sec_tick = 1'b0;
    endtask

    // Decode an ASCII character into strobes for one clock; returns just after that edge.
    task automatic send(input logic [7:0] c, input logic tick = 1'b0);
        logic [7:0] d;
        @(negedge clk);
        d = c - 8'h30;
        bif.rx_valid    = 1'b1;
        bif.det_num     = (c >= 8'h30) && (c <= 8'h39);
        bif.det_num0to5 = (c >= 8'h30) && (c <= 8'h35);
        bif.rx_digit    = bif.det_num ? d[3:0] : 4'd0;
        bif.det_cr      = (c == 8'h0D);
        bif.det_atSign  = (c == 8'h40);
        bif.det_A       = (c == 8'h41) || (c == 8'h61);
        bif.det_L       = (c == 8'h4C) || (c == 8'h6C);
        bif.det_S       = (c == 8'h53) || (c == 8'h73);
        bif.sec_tick    = tick;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bif.sec_tick = 1'b1;
            @(negedge clk);
            bif.sec_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (outs_all !== 23'd0) $display("FAIL reset_outputs: got %h want 000000", outs_all);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_time_entry();
        int ct0 = cnt_ct;
        send("L");
        n_total++;
        if ({bif.ld_time, bif.ld_alarm, bif.clk_run} !== 3'b100)
            $display("FAIL time_ld_after_L: got %b want 100", {bif.ld_time, bif.ld_alarm, bif.clk_run});
        else n_pass++;
        send("1"); send("2"); send("3");
        n_total++;
        if (bif.ld_time !== 1'b1) $display("FAIL time_ld_before_last: got %b want 1", bif.ld_time);
        else n_pass++;
        send("4");
        n_total++;
        if ({bif.commit_time, bif.commit_alarm, bif.ld_time} !== 3'b100)
            $display("FAIL time_commit_pulse: got %b want 100", {bif.commit_time, bif.commit_alarm, bif.ld_time});
        else n_pass++;
        n_total++;
        if (dig_all !== 16'h1234) $display("FAIL time_digits: got %h want 1234", dig_all);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bif.commit_time !== 1'b0 || cnt_ct - ct0 != 1)
            $display("FAIL time_commit_one_cycle: got %b/%0d want 0/1", bif.commit_time, cnt_ct - ct0);
        else n_pass++;
    endtask

    task automatic test_alarm_entry();
        int ca0 = cnt_ca;
        send("a");
        n_total++;
        if ({bif.ld_time, bif.ld_alarm} !== 2'b01)
            $display("FAIL alarm_ld: got %b want 01", {bif.ld_time, bif.ld_alarm});
        else n_pass++;
        send("5"); send("9"); send("0"); send("0");
        n_total++;
        if ({bif.commit_alarm, bif.commit_time} !== 2'b10 || dig_all !== 16'h5900)
            $display("FAIL alarm_commit: got %b %h want 10 5900", {bif.commit_alarm, bif.commit_time}, dig_all);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cnt_ca - ca0 != 1) $display("FAIL alarm_commit_count: got %0d want 1", cnt_ca - ca0);
        else n_pass++;
        n_total++;
        if (bif.alarm_ena !== 1'b0) $display("FAIL alarm_ena_unchanged: got %b want 0", bif.alarm_ena);
        else n_pass++;
        send("@");
        n_total++;
        if (bif.alarm_ena !== 1'b1) $display("FAIL alarm_ena_on: got %b want 1", bif.alarm_ena);
        else n_pass++;
        send("@");
        n_total++;
        if (bif.alarm_ena !== 1'b0) $display("FAIL alarm_ena_off: got %b want 0", bif.alarm_ena);
        else n_pass++;
    endtask

    task automatic test_abort();
        int ct0 = cnt_ct;
        int ca0 = cnt_ca;
        int e0  = cnt_err;
        send("L"); send("6");
        n_total++;
        if ({bif.entry_err, bif.ld_time} !== 2'b10)
            $display("FAIL abort_bad_digit: got %b want 10", {bif.entry_err, bif.ld_time});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bif.entry_err !== 1'b0 || cnt_err - e0 != 1 || dig_all !== 16'h5900)
            $display("FAIL abort_err_pulse: got %b/%0d/%h want 0/1/5900", bif.entry_err, cnt_err - e0, dig_all);
        else n_pass++;
        send("L"); send("1"); send(8'h0D);
        @(negedge clk);
        n_total++;
        if (bif.ld_time !== 1'b0 || cnt_err - e0 != 1)
            $display("FAIL abort_cr_silent: got %b/%0d want 0/1", bif.ld_time, cnt_err - e0);
        else n_pass++;
        n_total++;
        if (cnt_ct != ct0 || cnt_ca != ca0)
            $display("FAIL abort_no_commit: got %0d/%0d want 0/0", cnt_ct - ct0, cnt_ca - ca0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int ct0 = cnt_ct;
        int e0  = cnt_err;
        send("L"); send("1"); send("2");
        tick(9);
        n_total++;
        if ({bif.ld_time, bif.entry_err} !== 2'b10)
            $display("FAIL timeout_9_ticks: got %b want 10", {bif.ld_time, bif.entry_err});
        else n_pass++;
        tick(1);
        n_total++;
        if ({bif.entry_err, bif.ld_time} !== 2'b10)
            $display("FAIL timeout_10th_tick: got %b want 10", {bif.entry_err, bif.ld_time});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cnt_err - e0 != 1 || cnt_ct != ct0 || dig_all !== 16'h5900)
            $display("FAIL timeout_no_commit: got %0d/%0d/%h want 1/0/5900", cnt_err - e0, cnt_ct - ct0, dig_all);
        else n_pass++;
        send("L"); send("1"); send("2");
        tick(9);
        send("3", 1'b1);
        n_total++;
        if ({bif.ld_time, bif.entry_err} !== 2'b10)
            $display("FAIL timeout_digit_beats_tick: got %b want 10", {bif.ld_time, bif.entry_err});
        else n_pass++;
        tick(9);
        send("4");
        n_total++;
        if (bif.commit_time !== 1'b1 || dig_all !== 16'h1234)
            $display("FAIL timeout_late_commit: got %b %h want 1 1234", bif.commit_time, dig_all);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cnt_err - e0 != 1) $display("FAIL timeout_err_count: got %0d want 1", cnt_err - e0);
        else n_pass++;
    endtask

    task automatic test_restart();
        int ct0 = cnt_ct;
        int ca0 = cnt_ca;
        send("L"); send("1");
        n_total++;
        if ({bif.ld_time, bif.ld_alarm} !== 2'b10)
            $display("FAIL restart_time_first: got %b want 10", {bif.ld_time, bif.ld_alarm});
        else n_pass++;
        send("A");
        n_total++;
        if ({bif.ld_time, bif.ld_alarm} !== 2'b01)
            $display("FAIL restart_switch_mode: got %b want 01", {bif.ld_time, bif.ld_alarm});
        else n_pass++;
        send("0"); send("0"); send("0"); send("0");
        n_total++;
        if ({bif.commit_alarm, bif.commit_time} !== 2'b10 || dig_all !== 16'h0000)
            $display("FAIL restart_commit: got %b %h want 10 0000", {bif.commit_alarm, bif.commit_time}, dig_all);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cnt_ct != ct0 || cnt_ca - ca0 != 1)
            $display("FAIL restart_counts: got %0d/%0d want 0/1", cnt_ct - ct0, cnt_ca - ca0);
        else n_pass++;
    endtask

    task automatic test_run();
        int ct0 = cnt_ct;
        send("S");
        n_total++;
        if (bif.clk_run !== 1'b1) $display("FAIL run_S: got %b want 1", bif.clk_run);
        else n_pass++;
        send("L");
        n_total++;
        if ({bif.clk_run, bif.ld_time} !== 2'b01)
            $display("FAIL run_held_by_entry: got %b want 01", {bif.clk_run, bif.ld_time});
        else n_pass++;
        send("1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (outs_all !== 23'd0 || cnt_ct != ct0)
            $display("FAIL run_reset_mid_entry: got %h/%0d want 000000/0", outs_all, cnt_ct - ct0);
        else n_pass++;
        rst = 1'b0;
        send("s");
        n_total++;
        if (bif.clk_run !== 1'b1) $display("FAIL run_S_after_reset: got %b want 1", bif.clk_run);
        else n_pass++;
        send(8'h0D);
        n_total++;
        if (bif.clk_run !== 1'b0) $display("FAIL run_cr_stop: got %b want 0", bif.clk_run);
        else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_time_entry();
        test_alarm_entry();
        test_abort();
        test_timeout();
        test_restart();
        test_run();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
